// File: rtl/atriusb_event_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atriusb_event_bridge_pkg
// Purpose  : Constants shared between the event framer and the event bridge.
//            Covers the frame-start codes, the header and packet sizes, and
//            the bridge state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package atriusb_event_bridge_pkg;

  // Header length and USB bulk packet size. The header length is part of
  // the framer protocol.
  localparam int c_hdr_bytes = 4;
  localparam int c_pkt_bytes = 512;

  // Frame-start codes for header byte 0. They are compared with bit 5
  // cleared, so the lower-case forms are also accepted.
  localparam logic [7:0] c_code_evt       = 8'h45;
  localparam logic [7:0] c_code_beg       = 8'h42;
  localparam logic [7:0] c_code_frm       = 8'h46;
  localparam logic [7:0] c_code_oth       = 8'h4F;
  localparam logic [7:0] c_code_case_mask = 8'hDF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DONE    = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  function automatic logic is_frame_code(input logic [7:0] b);
    logic [7:0] m;
    m = b & c_code_case_mask;
    return (m == c_code_evt) || (m == c_code_beg) ||
           (m == c_code_frm) || (m == c_code_oth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/atriusb_hdr_check.sv
`default_nettype none
// ============================================================================
// Module   : atriusb_hdr_check
// Purpose  : Checks frame headers and tracks the expected frame number.
//            Byte 0 must be a frame-start code (bit 5 masked). Byte 1 must
//            equal the expected frame number. That number is 0 after reset or
//            after an end-of-block, and advances by one per completed frame.
//            The module exists only when ATRIUSB_BRIDGE_HDRCHK_EN is defined.
// Ports    : clk_i, rst_n_i          clock, asynchronous active-low reset
//            i_hdr_rd, i_hdr_idx     header byte consumed this cycle, index
//            i_dat                   the header byte being consumed
//            i_frame_done            frame completed (advance frame number)
//            i_block_clr             end of event block (frame number -> 0)
//            o_mismatch              current header byte is invalid
//            o_err                   sticky header error
// Revision : 1.0 - initial release
// ============================================================================
`ifdef ATRIUSB_BRIDGE_HDRCHK_EN
module atriusb_hdr_check
  import atriusb_event_bridge_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       i_hdr_rd,
  input  logic [2:0] i_hdr_idx,
  input  logic [7:0] i_dat,
  input  logic       i_frame_done,
  input  logic       i_block_clr,
  output logic       o_mismatch,
  output logic       o_err
);

  logic [7:0] r_exp_frame;
  logic       r_err;

  always_comb begin
    o_mismatch = 1'b0;
    if (i_hdr_rd) begin
      if (i_hdr_idx == 3'd0) begin
        o_mismatch = !is_frame_code(i_dat);
      end else if (i_hdr_idx == 3'd1) begin
        o_mismatch = (i_dat != r_exp_frame);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_exp_frame <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      if (i_block_clr) begin
        r_exp_frame <= 8'd0;
      end else if (i_frame_done) begin
        r_exp_frame <= r_exp_frame + 8'd1;
      end
      if (o_mismatch) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;

endmodule
`endif
`default_nettype wire

// File: rtl/atriusb_event_bridge.sv
`default_nettype none
// ============================================================================
// Module   : atriusb_event_bridge
// Purpose  : Reads frames from the USB event framer (4-byte header plus
//            payload) and writes them into an FX2 slave-FIFO IN endpoint.
//            Each frame occupies one USB packet. A packet shorter than
//            PKT_BYTES is committed with PKTEND.
//            The optional header check is enabled by ATRIUSB_BRIDGE_HDRCHK_EN.
// Ports    : clk_i, rst_n_i          clock, asynchronous active-low reset
//            bridge_dat_i            current framer byte
//            event_pending_i         framer has a byte available
//            event_empty_i           framer empty (stall while in payload)
//            block_done_i            last frame of the event finished
//            event_rd_o              consume current byte (combinational)
//            frame_done_o            frame payload complete pulse
//            ep_full_n_i             endpoint full flag (low = full)
//            ep_dat_o/ep_wr_o        registered endpoint write
//            ep_pktend_o             registered packet-commit pulse
//            busy_o                  bridge not idle
//            hdr_err_o               sticky header error
// Revision : 1.0 - initial release
// ============================================================================
module atriusb_event_bridge
  import atriusb_event_bridge_pkg::*;
#(
  parameter int PKT_BYTES = c_pkt_bytes,
  parameter int HDR_BYTES = c_hdr_bytes
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] bridge_dat_i,
  input  logic       event_pending_i,
  input  logic       event_empty_i,
  input  logic       block_done_i,
  output logic       event_rd_o,
  output logic       frame_done_o,
  input  logic       ep_full_n_i,
  output logic [7:0] ep_dat_o,
  output logic       ep_wr_o,
  output logic       ep_pktend_o,
  output logic       busy_o,
  output logic       hdr_err_o
);

  localparam int MAX_PAYLOAD = PKT_BYTES - HDR_BYTES;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_hdr_cnt;
  logic [9:0]  r_pay_cnt;
  logic [9:0]  r_pay_len;
  logic [7:0]  r_rem_lo;
  logic [2:0]  r_starve;
  logic        r_pkt_wr;     // at least one byte of this packet was written
  logic        r_hdr_bad;    // header rejected; abort on the next cycle
  logic        w_pktend_nxt;
  logic        w_in_xfer;
  logic        w_left;
  logic        w_hdr_rd;
  logic        w_pay_rd;
  logic        w_hdr_last;
  logic        w_pay_last;
  logic        w_abort;
  logic        w_hdr_mismatch;
  logic [15:0] w_rem;
  logic [9:0]  w_len_calc;

  assign w_in_xfer = (r_state == ST_HDR) || (r_state == ST_PAYLOAD);
  assign w_left    = (r_state == ST_HDR) ? (r_hdr_cnt < 3'(HDR_BYTES))
                                         : (r_pay_cnt < r_pay_len);

  // While in payload, an empty framer is treated as a stall, not as the end
  // of the frame.
  assign event_rd_o = w_in_xfer && event_pending_i && ep_full_n_i && w_left &&
                      !r_hdr_bad &&
                      !((r_state == ST_PAYLOAD) && event_empty_i);

  assign w_hdr_rd   = event_rd_o && (r_state == ST_HDR);
  assign w_pay_rd   = event_rd_o && (r_state == ST_PAYLOAD);
  assign w_hdr_last = w_hdr_rd && (r_hdr_cnt == 3'(HDR_BYTES - 1));
  assign w_pay_last = w_pay_rd && (r_pay_cnt == r_pay_len - 10'd1);

  // The upper remaining-length byte is on the bus as the last header byte is
  // read, so the full 16-bit length is compared before clamping.
  assign w_rem      = {bridge_dat_i, r_rem_lo};
  assign w_len_calc = (w_rem > 16'(MAX_PAYLOAD)) ? 10'(MAX_PAYLOAD) : w_rem[9:0];

  // Eight consecutive cycles without data mean the framer went through reset.
  assign w_abort = w_in_xfer &&
                   (r_hdr_bad || (!event_pending_i && (r_starve == 3'd7)));

  assign frame_done_o = (r_state == ST_DONE);
  assign busy_o       = (r_state != ST_IDLE);

`ifdef ATRIUSB_BRIDGE_HDRCHK_EN
  atriusb_hdr_check u_hdr_check (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .i_hdr_rd     (w_hdr_rd),
    .i_hdr_idx    (r_hdr_cnt),
    .i_dat        (bridge_dat_i),
    .i_frame_done (r_state == ST_DONE),
    .i_block_clr  ((r_state == ST_GAP) && block_done_i),
    .o_mismatch   (w_hdr_mismatch),
    .o_err        (hdr_err_o)
  );
`else
  // Without the header check there is no frame counter for block_done_i to
  // clear.
  logic w_unused_block_done;
  assign w_unused_block_done = block_done_i;
  assign w_hdr_mismatch      = 1'b0;
  assign hdr_err_o           = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pktend_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (event_pending_i) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (w_abort) begin
          w_state_nxt  = ST_GAP;
          w_pktend_nxt = r_pkt_wr;
        end else if (w_hdr_last) begin
          w_state_nxt = (w_len_calc == 10'd0) ? ST_DONE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_abort) begin
          w_state_nxt  = ST_GAP;
          w_pktend_nxt = r_pkt_wr;
        end else if (w_pay_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // A full-size packet commits itself; only short ones need PKTEND.
        w_pktend_nxt = (r_pay_len < 10'(MAX_PAYLOAD));
        w_state_nxt  = ST_GAP;
      end
      ST_GAP: begin
        if (!event_pending_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_hdr_cnt   <= 3'd0;
      r_pay_cnt   <= 10'd0;
      r_pay_len   <= 10'd0;
      r_rem_lo    <= 8'd0;
      r_starve    <= 3'd0;
      r_pkt_wr    <= 1'b0;
      r_hdr_bad   <= 1'b0;
      ep_dat_o    <= 8'd0;
      ep_wr_o     <= 1'b0;
      ep_pktend_o <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      ep_wr_o     <= event_rd_o;
      ep_pktend_o <= w_pktend_nxt;
      if (event_rd_o) begin
        ep_dat_o <= bridge_dat_i;
        r_pkt_wr <= 1'b1;
      end

      if (w_in_xfer && !event_pending_i) r_starve <= r_starve + 3'd1;
      else                               r_starve <= 3'd0;

      if (r_state == ST_IDLE) begin
        r_hdr_cnt <= 3'd0;
        r_pay_cnt <= 10'd0;
        r_pkt_wr  <= 1'b0;
        r_hdr_bad <= 1'b0;
      end

      if (w_hdr_rd) begin
        r_hdr_cnt <= r_hdr_cnt + 3'd1;
        if (r_hdr_cnt == 3'd2) r_rem_lo <= bridge_dat_i;
        if (w_hdr_last)        r_pay_len <= w_len_calc;
        if (w_hdr_mismatch)    r_hdr_bad <= 1'b1;
      end
      if (w_pay_rd) r_pay_cnt <= r_pay_cnt + 10'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atriusb_event_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_atriusb_event_bridge
// Purpose  : Randomised, scoreboard-checked bench for atriusb_event_bridge.
//            A framer model supplies one frame at a time. The expected
//            endpoint bytes, frame_done pulses and PKTEND pulses are queued
//            when each frame is issued. A monitor consumes those queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atriusb_event_bridge;

  localparam int MAXP = 508;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [7:0] bridge_dat_i;
  logic       event_pending_i;
  logic       event_empty_i = 1'b0;
  logic       block_done_i = 1'b0;
  logic       event_rd_o;
  logic       frame_done_o;
  logic       ep_full_n_i = 1'b1;
  logic [7:0] ep_dat_o;
  logic       ep_wr_o;
  logic       ep_pktend_o;
  logic       busy_o;
  logic       hdr_err_o;

  always #5 clk_i = ~clk_i;

  atriusb_event_bridge dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .bridge_dat_i    (bridge_dat_i),
    .event_pending_i (event_pending_i),
    .event_empty_i   (event_empty_i),
    .block_done_i    (block_done_i),
    .event_rd_o      (event_rd_o),
    .frame_done_o    (frame_done_o),
    .ep_full_n_i     (ep_full_n_i),
    .ep_dat_o        (ep_dat_o),
    .ep_wr_o         (ep_wr_o),
    .ep_pktend_o     (ep_pktend_o),
    .busy_o          (busy_o),
    .hdr_err_o       (hdr_err_o)
  );

  // Framer model state.
  logic [7:0] fbuf [0:1023];
  int         flen = 0, favail = 0, ptr = 0;
  logic       thr = 1'b0;
  int         off_run = 0, stall_left = 0;
  bit         rnd_full = 1'b0;
  logic [7:0] fnum = 8'd0;

  assign bridge_dat_i    = fbuf[ptr[9:0]];
  assign event_pending_i = (ptr < favail) && thr;

  // Scoreboard.
  logic [7:0] q_wr [$];
  int         q_fd [$];
  int         q_pe [$];
  int         n_wr = 0, n_fd = 0, n_pe = 0;
  int         base_wr, base_fd, base_pe, exp_wr, exp_fd, exp_pe;
  int         total = 0, bad = 0;
  bit         mon_en = 1'b0;
  logic       prev_full = 1'b1;
  logic [7:0] e;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk_i) begin
    if (mon_en && rst_n_i) begin
      if (!ep_full_n_i) chk("rd_while_full", event_rd_o, 0);
      if (!prev_full)   chk("wr_after_full", ep_wr_o, 0);
      if (ep_wr_o) begin
        n_wr++;
        if (q_wr.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          e = q_wr.pop_front();
          chk("wr_data", ep_dat_o, e);
        end
      end
      if (frame_done_o) begin
        n_fd++;
        if (q_fd.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          void'(q_fd.pop_front());
          chk("frame_done_after_writes", q_wr.size(), 0);
        end
      end
      if (ep_pktend_o) begin
        n_pe++;
        if (q_pe.size() == 0) chk("unexpected_pktend", 1, 0);
        else begin
          void'(q_pe.pop_front());
          chk("pktend_after_writes", q_wr.size(), 0);
        end
      end
    end
    prev_full = ep_full_n_i;
  end

  // One clock of framer/endpoint activity. Inputs change 2 ns after the edge.
  task automatic step();
    logic rd_s;
    @(negedge clk_i);
    #1 rd_s = event_rd_o;
    @(posedge clk_i);
    #2;
    if (rd_s) ptr++;
    if (off_run >= 4 || $urandom_range(0, 3) != 0) begin
      thr = 1'b1; off_run = 0;
    end else begin
      thr = 1'b0; off_run++;
    end
    if (stall_left > 0) begin
      ep_full_n_i = 1'b0; stall_left--;
    end else begin
      ep_full_n_i = rnd_full ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
    event_empty_i = ($urandom_range(0, 9) == 0);
  endtask

  // lim < 0: the whole frame is available. lim >= 0: only lim bytes ever
  // arrive, so the bridge must abort.
  task automatic load_frame(input logic [7:0] typ, input int rem, input int lim,
                            input bit last);
    int plen;
    plen = (rem > MAXP) ? MAXP : rem;
    fbuf[0] = typ;
    fbuf[1] = fnum;
    fbuf[2] = rem[7:0];
    fbuf[3] = rem[15:8];
    for (int i = 0; i < plen; i++) fbuf[4 + i] = 8'($urandom);
    flen   = 4 + plen;
    favail = (lim >= 0) ? lim : flen;
    for (int i = 0; i < favail; i++) q_wr.push_back(fbuf[i]);
    exp_wr = favail;
    if (lim < 0) begin
      q_fd.push_back(1);
      exp_fd = 1;
      exp_pe = (4 + plen < 512) ? 1 : 0;
      fnum++;
      if (last) fnum = 8'd0;
    end else begin
      exp_fd = 0;
      exp_pe = (lim > 0) ? 1 : 0;
    end
    if (exp_pe != 0) q_pe.push_back(1);
    block_done_i = last && (lim < 0);
    base_wr = n_wr; base_fd = n_fd; base_pe = n_pe;
    ptr = 0;
  endtask

  task automatic run_frame(input int stall_at);
    int n;
    int p0;
    bit stalled;
    stalled = 1'b0;
    for (n = 0; n < 6000; n++) begin
      step();
      if (!stalled && stall_at >= 0 && ptr >= stall_at) begin
        stalled = 1'b1;
        p0 = ptr;
        ep_full_n_i = 1'b0;
        stall_left = 19;
        for (int k = 0; k < 20; k++) step();
        chk("stall_no_read", ptr, p0);
      end
      if (ptr == favail && !busy_o) break;
    end
    chk("frame_timeout", (n < 6000) ? 1 : 0, 1);
    step();
    step();
    chk("frame_writes", n_wr - base_wr, exp_wr);
    chk("frame_done_count", n_fd - base_fd, exp_fd);
    chk("pktend_count", n_pe - base_pe, exp_pe);
    chk("queues_drained", q_wr.size() + q_fd.size() + q_pe.size(), 0);
    block_done_i = 1'b0;
  endtask

  task automatic run_event(input int rem0, input logic [7:0] typ);
    int r;
    r = rem0;
    do begin
      load_frame(typ, r, -1, r <= MAXP);
      run_frame(-1);
      r = (r > MAXP) ? r - MAXP : 0;
    end while (r > 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_wr", ep_wr_o, 0);
    chk("rst_pktend", ep_pktend_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_dat", ep_dat_o, 0);
    chk("rst_hdr_err", hdr_err_o, 0);
    rst_n_i = 1'b1;
    mon_en  = 1'b1;

    // Directed frames and events.
    run_event(200, 8'h45);
    run_event(1200, 8'h42);
    run_event(508, 8'h46);
    run_event(507, 8'h4F);
    run_event(509, 8'h65);
    run_event(0, 8'h45);
    run_event(16'hFFFF, 8'h46);

    // 20 cycles of endpoint backpressure in the middle of the payload.
    load_frame(8'h45, 300, -1, 1'b1);
    run_frame(100);

    // The framer stops supplying bytes: abort in payload, then in header.
    load_frame(8'h46, 300, 60, 1'b0);
    run_frame(-1);
    load_frame(8'h46, 300, 2, 1'b0);
    run_frame(-1);
    run_event(40, 8'h45);

    // Invalid frame-start code.
`ifdef ATRIUSB_BRIDGE_HDRCHK_EN
    load_frame(8'h41, 20, 1, 1'b0);
    run_frame(-1);
    chk("hdr_err_set", hdr_err_o, 1);
    chk("gap_then_idle", busy_o, 0);
`else
    load_frame(8'h41, 20, -1, 1'b1);
    run_frame(-1);
    chk("hdr_err_clear", hdr_err_o, 0);
`endif

    // Random events with random backpressure.
    rnd_full = 1'b1;
    for (int i = 0; i < 6; i++) run_event($urandom_range(0, 1100), 8'h46);
    rnd_full = 1'b0;

    // Asynchronous reset in the middle of the payload.
    load_frame(8'h46, 300, -1, 1'b0);
    for (int n = 0; n < 3000 && ptr < 50; n++) step();
    chk("reached_mid_payload", (ptr >= 50) ? 1 : 0, 1);
    mon_en = 1'b0;
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    chk("async_rst_wr", ep_wr_o, 0);
    chk("async_rst_pktend", ep_pktend_o, 0);
    chk("async_rst_frame_done", frame_done_o, 0);
    chk("async_rst_rd", event_rd_o, 0);
    chk("async_rst_busy", busy_o, 0);
    q_wr.delete(); q_fd.delete(); q_pe.delete();
    favail = 0; ptr = 0; fnum = 8'd0;
    repeat (2) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    step();
    chk("post_reset_idle", busy_o, 0);
    mon_en = 1'b1;
    run_event(77, 8'h45);

    chk("final_queues_empty", q_wr.size() + q_fd.size() + q_pe.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
